// File: rtl/hps_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hps_mac_ctrl
// Brief    : Job controller for a precision-scalable MAC. Issues operand pairs
//            to an external 2-cycle multiplier and accumulates its products.
//            Define HPS_MAC_CTRL_SAT_EN for saturating accumulation.
// Revision : 1.0
// ============================================================================
module hps_mac_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       start_mode,
  input  logic [LEN_W-1:0] start_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  output logic [1:0]       mul_mode,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_err
);

  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_RUN       = 2'd1;
  localparam logic [1:0] c_ST_DRAIN     = 2'd2;
  localparam logic [1:0] c_ST_DONE      = 2'd3;
  localparam logic [1:0] c_MODE_ILLEGAL = 2'b01;
  localparam logic [1:0] c_MODE_IDLE    = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_alive;
  logic [1:0]       r_mode;
  logic [LEN_W:0]   r_len;
  logic [LEN_W:0]   r_issued;
  logic             r_v1;
  logic             r_v2;
  logic [7:0]       r_mul_x;
  logic [7:0]       r_mul_y;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_prod;
  logic             r_err;
  logic             r_sat;
  logic             w_sat_set;
  logic             w_start_hs;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_v0;
  logic             w_last_issue;

  assign w_start_hs   = start_valid & start_ready;
  assign w_in_hs      = in_valid & in_ready;
  assign w_out_hs     = out_valid & out_ready;
  assign w_v0         = w_in_hs;
  assign w_last_issue = w_in_hs && ((r_issued + 1'b1) == r_len);

  // Operands pass straight through on an issue and are held otherwise.
  assign mul_x   = w_in_hs ? in_x : r_mul_x;
  assign mul_y   = w_in_hs ? in_y : r_mul_y;
  assign out_acc = r_acc;
  assign out_err = r_err;
  assign w_prod  = ACC_W'($signed(mul_p));

`ifdef HPS_MAC_CTRL_SAT_EN
  logic [ACC_W:0] w_sum;
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};

  // Overflow when the two top bits of the widened sum disagree.
  always_comb begin
    w_sat_set = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    if (!w_sat_set)
      w_acc_nxt = w_sum[ACC_W-1:0];
    else if (w_sum[ACC_W])
      w_acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
    else
      w_acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign w_acc_nxt = r_acc + w_prod;
  assign w_sat_set = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= c_ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_hs)
          w_state_nxt = (start_mode == c_MODE_ILLEGAL) ? c_ST_DONE : c_ST_RUN;
      end
      c_ST_RUN: begin
        if (w_last_issue)
          w_state_nxt = c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        // The product in stage 2 is folded in on this same edge.
        if (!w_v0 && !r_v1)
          w_state_nxt = c_ST_DONE;
      end
      c_ST_DONE: begin
        if (w_out_hs)
          w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    mul_mode    = r_mode;
    case (r_state)
      c_ST_IDLE: begin
        start_ready = r_alive;
        mul_mode    = c_MODE_IDLE;
      end
      c_ST_RUN:  in_ready  = (r_issued < r_len);
      c_ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive  <= 1'b0;
      r_mode   <= c_MODE_IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_mul_x  <= '0;
      r_mul_y  <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_v1    <= w_v0;
      r_v2    <= r_v1;
      if (w_in_hs) begin
        r_mul_x  <= in_x;
        r_mul_y  <= in_y;
        r_issued <= r_issued + 1'b1;
      end
      if (w_start_hs) begin
        r_mode   <= start_mode;
        r_len    <= (start_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, start_len};
        r_issued <= '0;
        r_acc    <= '0;
        r_sat    <= 1'b0;
        r_err    <= (start_mode == c_MODE_ILLEGAL);
      end else if (r_v2 && !r_sat) begin
        r_acc <= w_acc_nxt;
        r_sat <= w_sat_set;
      end
    end
  end

endmodule
`default_nettype wire
